// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   - MC_WIDTH   : default operand width (iteration count equals width)
//   - MC_MULU/MC_MULS/MC_DIVU/MC_DIVS : MCycleOp encodings
//   - mc_state_t : two-state controller encoding
package mcycle_pkg;

    localparam int MC_WIDTH = 32;

    localparam logic [1:0] MC_MULU = 2'b00;
    localparam logic [1:0] MC_MULS = 2'b01;
    localparam logic [1:0] MC_DIVU = 2'b10;
    localparam logic [1:0] MC_DIVS = 2'b11;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_COMP = 1'b1
    } mc_state_t;

endpackage

// File: rtl/mcycle_step.sv
// mcycle_step: one radix-2 iteration, purely combinational.
//   acc      in  2*WIDTH  multiply: {partial sum, remaining multiplier}
//                         divide:   {partial remainder, remaining dividend}
//   operand  in  WIDTH    multiplicand magnitude or divisor magnitude
//   div_mode in  1        0 = shift-add multiply, 1 = restoring divide
//   acc_next out 2*WIDTH  accumulator after this iteration (divide: bit 0 is 0)
//   q_bit    out 1        quotient bit produced by this divide iteration
module mcycle_step
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MC_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] dvd_sh_s;
    logic             ge_s;

    // Single iteration of either shift-add multiply or restoring divide.
    always_comb begin
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]};
        rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
        dvd_sh_s = {acc[WIDTH-2:0], 1'b0};
        diff_s   = {1'b0, rem_sh_s[WIDTH-1:0]} - {1'b0, operand};
        ge_s     = 1'b0;
        acc_next = acc;
        q_bit    = 1'b0;
        if (div_mode) begin
            // The shifted remainder is < 2*divisor, so if its top bit is set it
            // certainly exceeds the divisor; otherwise the borrow of the
            // WIDTH+1 subtraction is the compare result.
            ge_s = rem_sh_s[WIDTH] | ~diff_s[WIDTH];
            if (ge_s) begin
                acc_next = {diff_s[WIDTH-1:0], dvd_sh_s};
            end else begin
                acc_next = {rem_sh_s[WIDTH-1:0], dvd_sh_s};
            end
            q_bit = ge_s;
        end else begin
            if (acc[0]) begin
                sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
            end else begin
                sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
            end
            // Carry out of the add becomes the new MSB after the right shift.
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: multi-cycle 32x32 multiply / divide unit (radix-2, WIDTH iterations).
//   CLK       in  1      core clock, rising edge
//   Reset     in  1      asynchronous active-high reset
//   Start     in  1      start request (condition-qualified MULWrite)
//   MCycleOp  in  2      00 mulu, 01 muls, 10 divu, 11 divs
//   Operand1  in  WIDTH  multiplicand / dividend
//   Operand2  in  WIDTH  multiplier / divisor
//   Result1   out WIDTH  product low word / quotient
//   Result2   out WIDTH  product high word / remainder
//   Busy      out 1      stall request (combinational from Start in IDLE)
//   Done      out 1      one-cycle pulse when results become valid
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MC_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH) + 1;

    mc_state_t          state_r;
    logic [1:0]         op_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH-1:0]   orig1_r;
    logic               sign1_r;
    logic               sign2_r;
    logic [CW-1:0]      count_r;
    logic [WIDTH-1:0]   result1_r;
    logic [WIDTH-1:0]   result2_r;
    logic               done_r;

    logic               op_signed_s;
    logic               op_div_s;
    logic [WIDTH-1:0]   mag1_s;
    logic [WIDTH-1:0]   mag2_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic               step_q_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic               is_div_r_s;
    logic               is_signed_r_s;
    logic               last_s;
    logic [2*WIDTH-1:0] prod_neg_s;
    logic [WIDTH-1:0]   quot_neg_s;
    logic [WIDTH-1:0]   rem_neg_s;
    logic [WIDTH-1:0]   fix_r1_s;
    logic [WIDTH-1:0]   fix_r2_s;

    mcycle_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_r),
        .operand  (opnd_r),
        .div_mode (is_div_r_s),
        .acc_next (step_acc_s),
        .q_bit    (step_q_s)
    );

    // Operand magnitudes for the start edge (absolute value only for signed ops).
    always_comb begin
        op_signed_s = (MCycleOp == MC_MULS) || (MCycleOp == MC_DIVS);
        op_div_s    = (MCycleOp == MC_DIVU) || (MCycleOp == MC_DIVS);
        if (op_signed_s && Operand1[WIDTH-1]) begin
            mag1_s = ~Operand1 + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag1_s = Operand1;
        end
        if (op_signed_s && Operand2[WIDTH-1]) begin
            mag2_s = ~Operand2 + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag2_s = Operand2;
        end
    end

    // Merge the quotient bit into the vacated LSB and derive the sign fix-up.
    always_comb begin
        is_div_r_s    = (op_r == MC_DIVU) || (op_r == MC_DIVS);
        is_signed_r_s = (op_r == MC_MULS) || (op_r == MC_DIVS);
        last_s        = (count_r == CW'(WIDTH - 1));
        acc_next_s    = {step_acc_s[2*WIDTH-1:1], step_acc_s[0] | step_q_s};
        prod_neg_s    = ~acc_next_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        quot_neg_s    = ~acc_next_s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
        rem_neg_s     = ~acc_next_s[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1};
        fix_r1_s      = acc_next_s[WIDTH-1:0];
        fix_r2_s      = acc_next_s[2*WIDTH-1:WIDTH];
        if (is_div_r_s) begin
            if (opnd_r == {WIDTH{1'b0}}) begin
                // Divide by zero: fixed quotient, remainder is the original dividend.
                fix_r1_s = {WIDTH{1'b1}};
                fix_r2_s = orig1_r;
            end else if (is_signed_r_s) begin
                fix_r1_s = (sign1_r ^ sign2_r) ? quot_neg_s : acc_next_s[WIDTH-1:0];
                fix_r2_s = sign1_r ? rem_neg_s : acc_next_s[2*WIDTH-1:WIDTH];
            end else begin
                fix_r1_s = acc_next_s[WIDTH-1:0];
                fix_r2_s = acc_next_s[2*WIDTH-1:WIDTH];
            end
        end else begin
            if (is_signed_r_s && (sign1_r ^ sign2_r)) begin
                fix_r1_s = prod_neg_s[WIDTH-1:0];
                fix_r2_s = prod_neg_s[2*WIDTH-1:WIDTH];
            end else begin
                fix_r1_s = acc_next_s[WIDTH-1:0];
                fix_r2_s = acc_next_s[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Controller: capture on start, iterate while computing, publish on the last edge.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r   <= MC_IDLE;
            op_r      <= 2'b00;
            acc_r     <= {(2*WIDTH){1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            orig1_r   <= {WIDTH{1'b0}};
            sign1_r   <= 1'b0;
            sign2_r   <= 1'b0;
            count_r   <= {CW{1'b0}};
            result1_r <= {WIDTH{1'b0}};
            result2_r <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                MC_IDLE: begin
                    done_r <= 1'b0;
                    if (Start) begin
                        op_r    <= MCycleOp;
                        orig1_r <= Operand1;
                        sign1_r <= op_signed_s & Operand1[WIDTH-1];
                        sign2_r <= op_signed_s & Operand2[WIDTH-1];
                        // Low half holds the bits consumed one per iteration:
                        // the multiplier for multiply, the dividend for divide.
                        if (op_div_s) begin
                            acc_r  <= {{WIDTH{1'b0}}, mag1_s};
                            opnd_r <= mag2_s;
                        end else begin
                            acc_r  <= {{WIDTH{1'b0}}, mag2_s};
                            opnd_r <= mag1_s;
                        end
                        count_r <= {CW{1'b0}};
                        state_r <= MC_COMP;
                    end else begin
                        state_r <= MC_IDLE;
                    end
                end
                MC_COMP: begin
                    acc_r   <= acc_next_s;
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        result1_r <= fix_r1_s;
                        result2_r <= fix_r2_s;
                        done_r    <= 1'b1;
                        state_r   <= MC_IDLE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= MC_COMP;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= MC_IDLE;
                end
            endcase
        end
    end

    // Busy covers the request cycle itself so the core stalls immediately.
    assign Busy    = ((state_r == MC_IDLE) & Start) | (state_r == MC_COMP);
    assign Done    = done_r;
    assign Result1 = result1_r;
    assign Result2 = result2_r;

endmodule

// File: tb/tb_mcycle_unit.sv
module tb_mcycle_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;

    int n_checks = 0;
    int n_pass   = 0;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: results straight from integer arithmetic, returned as {Result2, Result1}.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (op)
            2'b00: p = {32'd0, a} * {32'd0, b};
            2'b01: p = sa * sb;
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Called just after a rising edge: raise Start with the operation and check Busy.
    task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        #1;
        check_value("busy_on_start", {63'd0, Busy}, 64'd1);
    endtask

    // Runs from the Start cycle to completion; scrambles inputs and re-pulses Start
    // at cycle 5 to show they are ignored while computing.
    task automatic wait_done(input string tag, input logic [31:0] e1, input logic [31:0] e2);
        int cyc;
        bit early;
        cyc   = 0;
        early = 1'b0;
        while (Busy === 1'b1 && cyc < 100) begin
            @(posedge CLK);
            #1;
            cyc++;
            Start    = (cyc == 5);
            MCycleOp = 2'($urandom);
            Operand1 = $urandom;
            Operand2 = $urandom;
            #1;
            if (Busy === 1'b1 && Done === 1'b1) early = 1'b1;
        end
        Start = 1'b0;
        #1;
        check_value({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
        check_value({tag, "_done_early"}, {63'd0, early}, 64'd0);
        check_value({tag, "_done"}, {63'd0, Done}, 64'd1);
        check_value({tag, "_result1"}, {32'd0, Result1}, {32'd0, e1});
        check_value({tag, "_result2"}, {32'd0, Result2}, {32'd0, e2});
    endtask

    // One cycle later: Done must have dropped and the results must hold.
    task automatic check_after(input string tag, input logic [31:0] e1, input logic [31:0] e2);
        @(posedge CLK);
        #2;
        check_value({tag, "_done_pulse"}, {62'd0, Done, Busy}, 64'd0);
        check_value({tag, "_hold"}, {Result2, Result1}, {e2, e1});
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t dir[8];

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'($urandom_range(0, 20));
            4: v = 32'd0 - 32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] exp;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          seen;

        dir[0] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0001};
        dir[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 32'hFFFF_FFFF};
        dir[2] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        dir[3] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        dir[4] = '{2'b10, 32'd100,       32'd7,         32'd14,        32'd2};
        dir[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        dir[6] = '{2'b10, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100};
        dir[7] = '{2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};

        Reset    = 1'b1;
        Start    = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = 32'd0;
        Operand2 = 32'd0;
        #12;
        check_value("reset_state", {Result2, Result1}, 64'd0);
        check_value("reset_flags", {62'd0, Busy, Done}, 64'd0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;

        // Directed cases with hand-derived expectations.
        for (int i = 0; i < 8; i++) begin
            do_start(dir[i].op, dir[i].a, dir[i].b);
            wait_done($sformatf("dir%0d", i), dir[i].e1, dir[i].e2);
            check_after($sformatf("dir%0d", i), dir[i].e1, dir[i].e2);
            @(posedge CLK);
            #1;
        end

        // Reset in cycle 10 of a divide.
        do_start(2'b10, 32'h1234_5678, 32'd3);
        for (int i = 1; i <= 10; i++) begin
            @(posedge CLK);
            #1;
            Start = 1'b0;
        end
        Reset = 1'b1;
        #1;
        check_value("midreset_outputs", {Result2, Result1}, 64'd0);
        check_value("midreset_flags", {62'd0, Busy, Done}, 64'd0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #2;
            if (Done === 1'b1 || Busy === 1'b1) seen = 1'b1;
        end
        check_value("midreset_no_done", {63'd0, seen}, 64'd0);
        @(posedge CLK);
        #1;

        // Fresh op after reset, then back-to-back start in its Done cycle.
        exp = ref_model(2'b10, 32'h1234_5678, 32'd3);
        do_start(2'b10, 32'h1234_5678, 32'd3);
        wait_done("after_reset", exp[31:0], exp[63:32]);
        do_start(2'b01, 32'hFFFF_FFF0, 32'd7);
        check_value("b2b_done_still", {63'd0, Done}, 64'd1);
        check_value("b2b_results_held", {Result2, Result1}, exp);
        exp = ref_model(2'b01, 32'hFFFF_FFF0, 32'd7);
        wait_done("b2b", exp[31:0], exp[63:32]);
        check_after("b2b", exp[31:0], exp[63:32]);
        @(posedge CLK);
        #1;

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom);
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_model(op, a, b);
            do_start(op, a, b);
            wait_done($sformatf("rnd%0d_op%0d", i, op), exp[31:0], exp[63:32]);
            if ($urandom_range(0, 1) == 0) begin
                check_after($sformatf("rnd%0d", i), exp[31:0], exp[63:32]);
                @(posedge CLK);
                #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d checks done", n_checks);
        $fatal(1);
    end

endmodule
